// File: rtl/spi_slave_sync_if.sv
// rtl/spi_slave_sync_if.sv - pin and host-side bundle for spi_slave_sync (SPI_SLAVE_FRAME_ERR_EN adds frame_err/rx_ovr/rx_ack)
interface spi_slave_sync_if #(
  parameter int WIDTH = 13
);
  logic             sclk;
  logic             cs_n;
  logic             mosi;
  logic             miso;
  logic             miso_oe;
  logic [WIDTH-1:0] stx_dat;
  logic             load;
  logic [WIDTH-1:0] srx_dat;
  logic             rx_vld;
  logic             busy;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic             frame_err;
  logic             rx_ovr;
  logic             rx_ack;

  modport slave (
    input  sclk, cs_n, mosi, stx_dat, load, rx_ack,
    output miso, miso_oe, srx_dat, rx_vld, busy, frame_err, rx_ovr
  );

  modport master (
    output sclk, cs_n, mosi, stx_dat, load, rx_ack,
    input  miso, miso_oe, srx_dat, rx_vld, busy, frame_err, rx_ovr
  );
`else
  modport slave (
    input  sclk, cs_n, mosi, stx_dat, load,
    output miso, miso_oe, srx_dat, rx_vld, busy
  );

  modport master (
    output sclk, cs_n, mosi, stx_dat, load,
    input  miso, miso_oe, srx_dat, rx_vld, busy
  );
`endif
endinterface

// File: rtl/spi_slave_sync.sv
// rtl/spi_slave_sync.sv - SPI mode-0 slave oversampled on clk; optional feature macro SPI_SLAVE_FRAME_ERR_EN
module spi_slave_sync #(
  parameter int WIDTH       = 13,
  parameter int SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             rst,
  spi_slave_sync_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_ACTIVE     = 2'd1,
    S_WAIT_DESEL = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nx;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_d;
  logic [SYNC_STAGES:0]   flush;

  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   rise;
  logic                   fall;
  logic                   cs_fall;
  logic                   cs_rise;
  logic                   flushed;
  logic                   word_done;

  logic [WIDTH-1:0]       tx_buf;
  logic [WIDTH-1:0]       tx_sh;
  logic [WIDTH-1:0]       rx_sh;
  logic [WIDTH-1:0]       reload_word;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   miso_q;
  logic [WIDTH-1:0]       srx_q;
  logic                   rx_vld_q;
  logic                   active;

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_d;
  assign fall    = ~sclk_s & sclk_d;
  assign cs_fall = ~cs_s & cs_d;
  assign cs_rise = cs_s & ~cs_d;
  // The reset fill looks like an idle bus; wait until real pin values have
  // propagated so a frame held across reset is not mistaken for a new select.
  assign flushed = flush[SYNC_STAGES];

  assign word_done   = (state == S_ACTIVE) && rise && (bit_cnt == LAST_BIT);
  // A load in the same clk as a reload goes straight to the shifter.
  assign reload_word = bus.load ? bus.stx_dat : tx_buf;

  // Input synchronizers plus one edge-detect stage for sclk and cs_n.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      flush     <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      flush     <= {flush[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_WAIT_DESEL;
    else      state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_WAIT_DESEL: if (flushed && cs_s) state_nx = S_IDLE;
      S_IDLE:       if (cs_fall)         state_nx = S_ACTIVE;
      S_ACTIVE:     if (cs_rise)         state_nx = S_IDLE;
      default:                           state_nx = S_WAIT_DESEL;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    active = 1'b0;
    if (state == S_ACTIVE) active = 1'b1;
  end

  // Transmit/receive shifters, bit counter and received-word register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_buf   <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      bit_cnt  <= '0;
      miso_q   <= 1'b0;
      srx_q    <= '0;
      rx_vld_q <= 1'b0;
    end else begin
      rx_vld_q <= 1'b0;
      if (bus.load) tx_buf <= bus.stx_dat;
      case (state)
        S_IDLE: begin
          if (cs_fall) begin
            tx_sh   <= reload_word;
            miso_q  <= reload_word[WIDTH-1];
            bit_cnt <= '0;
          end
        end
        S_ACTIVE: begin
          if (rise) begin
            rx_sh <= {rx_sh[WIDTH-2:0], mosi_s};
            if (word_done) begin
              srx_q    <= {rx_sh[WIDTH-2:0], mosi_s};
              rx_vld_q <= 1'b1;
              bit_cnt  <= '0;
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end
          if (fall) begin
            if (bit_cnt != '0) begin
              tx_sh  <= {tx_sh[WIDTH-2:0], 1'b0};
              miso_q <= tx_sh[WIDTH-2];
            end else begin
              tx_sh  <= reload_word;
              miso_q <= reload_word[WIDTH-1];
            end
          end
          // Deselect wins over any shift; a final rise in this clk still completes.
          if (cs_rise) begin
            miso_q  <= 1'b0;
            bit_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.miso    = miso_q;
  assign bus.miso_oe = active;
  assign bus.busy    = active;
  assign bus.srx_dat = srx_q;
  assign bus.rx_vld  = rx_vld_q;

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic frame_err_q;
  logic rx_pend;
  logic rx_ovr_q;
  logic partial_end;

  assign partial_end = (state == S_ACTIVE) && cs_rise && !word_done &&
                       (rise || (bit_cnt != '0));

  // Frame-error pulse and overrun tracking against the host acknowledge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_err_q <= 1'b0;
      rx_pend     <= 1'b0;
      rx_ovr_q    <= 1'b0;
    end else begin
      frame_err_q <= partial_end;
      rx_pend     <= word_done | (rx_pend & ~bus.rx_ack);
      if (word_done && rx_pend && !bus.rx_ack) rx_ovr_q <= 1'b1;
      else if (bus.rx_ack)                     rx_ovr_q <= 1'b0;
    end
  end

  assign bus.frame_err = frame_err_q;
  assign bus.rx_ovr    = rx_ovr_q;
`endif

endmodule

// File: doc/spi_slave_sync.md
Name: spi_slave_sync

Overview:
- SPI mode-0 responder (slave) for the external-SCLK side of our SPI link; counterpart to the existing SPI master.
- Runs on the FPGA system clock and oversamples the asynchronous sclk, cs_n and mosi inputs through synchronizers.
- Shifts in MSB-first words of WIDTH bits and presents each completed word to the host logic. Simultaneously shifts out a host-loaded word on miso.

Parameters:
- WIDTH, 13, word length in bits; legal range 2..32.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers on sclk, cs_n and mosi; legal range 2..3.

Ports:
- clk  input  1  system clock; must be at least 4x the sclk frequency.
- rst  input  1  synchronous reset, active-low (0 = reset), sampled on rising clk.
- sclk  input  1  SPI clock from the master; asynchronous; idles low.
- cs_n  input  1  chip select from the master; asynchronous; active-low.
- mosi  input  1  master-out data; asynchronous.
- miso  output  1  slave-out data; registered.
- miso_oe  output  1  1 while the frame is selected; used for the external tristate.
- stx_dat  input  WIDTH  word to transmit.
- load  input  1  one-clk strobe that captures stx_dat into tx_buf.
- srx_dat  output  WIDTH  last complete received word.
- rx_vld  output  1  one-clk pulse when srx_dat updates.
- busy  output  1  1 while in ACTIVE state.

Behaviour:
- Reset (rst=0 at a clk edge):
  - All registers are cleared: miso=0, miso_oe=0, srx_dat=0, rx_vld=0, busy=0, tx_buf=0, bit_cnt=0, and the synchronizers are filled with idle values (sclk=0, cs_n=1).
  - Reset asserted mid-frame aborts the frame and no rx_vld is produced.
- Synchronization:
  - Each input passes through SYNC_STAGES flip-flops, plus one extra sclk stage for edge detection.
  - rise = synced sclk 0->1; fall = synced sclk 1->0.
  - cs_fall and cs_rise are detected the same way.
- State machine: IDLE, ACTIVE, WAIT_DESEL.
  - Reset enters WAIT_DESEL.
  - WAIT_DESEL goes to IDLE when synced cs_n=1. A frame already in progress at reset release is therefore ignored until the master deselects.
  - IDLE goes to ACTIVE on cs_fall:
    - the shift register is loaded from tx_buf;
    - miso is driven with tx_buf[WIDTH-1];
    - miso_oe=1, busy=1, bit_cnt=0.
    - Latency from the cs_n pin falling to miso valid is SYNC_STAGES+1 clk. The master must leave at least SYNC_STAGES+2 clk before the first sclk rise.
  - ACTIVE goes to IDLE on cs_rise: miso_oe=0, busy=0, miso=0, bit_cnt=0. A partial word is discarded and produces no rx_vld.
- Receive (ACTIVE, on rise):
  - rx_sh shifts left, taking in synced mosi; bit_cnt increments.
  - When bit_cnt==WIDTH-1 at a rise: srx_dat <= {rx_sh[WIDTH-2:0], mosi}, rx_vld=1 for exactly one clk, and bit_cnt wraps to 0.
- Transmit (ACTIVE, on fall):
  - If bit_cnt!=0, tx_sh shifts left and miso takes the new MSB.
  - If bit_cnt==0 (a word boundary inside a continuous frame), tx_sh reloads from tx_buf and miso takes tx_buf[WIDTH-1]. Back-to-back words therefore need no cs_n toggle.
- Load:
  - tx_buf captures stx_dat on load=1; this is allowed in any state.
  - If load coincides with a reload event (cs_fall, or a fall with bit_cnt==0), stx_dat is used directly, bypassing tx_buf.
  - With no new load, the previous tx_buf value is resent.
- rise and fall never coincide, because sclk is at most clk/4.
- A cs_rise in the same clk as the final rise completes the word first (rx_vld=1), then goes to IDLE.

Optional Feature:
- Macro: SPI_SLAVE_FRAME_ERR_EN.
- Defined:
  - Adds output frame_err (1 bit, reset 0).
  - frame_err pulses 1 clk when cs_rise occurs with bit_cnt!=0.
  - Adds output rx_ovr (1 bit, sticky), set when rx_vld fires while the previous word is unacknowledged. Acknowledgement is input rx_ack, a one-clk strobe that clears both the pending flag and rx_ovr.
- Not defined: none of these ports exist, and the partial-word discard is silent.

Test Plan:
- Settings: WIDTH=13, clk period 2, sclk period 8, driven by the existing master model.
- Test 1: After reset, load stx_dat=13'b0101001011001; master sends 13'b1001001001001 under one cs_n low.
  - srx_dat=13'h1249 with a single rx_vld pulse.
  - Master receives 13'h0A59.
  - miso_oe=1 only while cs_n is low.
- Test 2: Two words without raising cs_n, with load=13'h1FFF issued between them.
  - Second word out on miso = 13'h1FFF.
  - Two rx_vld pulses, 52 clk apart.
- Test 3: Raise cs_n after 5 bits, then run a full frame sending 13'h0AAA.
  - No rx_vld for the aborted frame.
  - The next frame gives srx_dat=13'h0AAA.
  - With SPI_SLAVE_FRAME_ERR_EN, frame_err pulses once.
- Test 4: Assert rst=0 mid-frame (bit 6), release it while cs_n is still low.
  - All outputs are 0.
  - Remaining bits are ignored (WAIT_DESEL).
  - The next full frame after cs_n high->low is received correctly.
- Test 5: Load pulse in the same clk as cs_fall with stx_dat=13'h1555.
  - miso MSB = 1.
  - Master receives 13'h1555, not the stale tx_buf.
- Test 6: No load between two frames.
  - The second frame retransmits the previous tx_buf value.
  - busy follows cs_n delayed by SYNC_STAGES+1 clk.
